mesm6_membus_arbiter: RTL and testbench

// - Shares one single-port 48-bit memory between the MESM-6 core instruction bus (ibus) and data bus (dbus).
// - Accepts level requests from the core and issues one memory transaction at a time.
// - Returns a one-cycle done pulse with registered read data, so the core's busy/stall logic works unchanged.
// - Sits between mesm6_core and the system memory, one instance per core.

---
 rtl/mesm6_membus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mesm6_membus_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_membus_arbiter.sv
// MESM-6 memory bus arbiter: one single-port memory shared by the core's ibus and dbus, dbus first with ibus anti-starvation.
// Define MESM6_IBUF_EN to add a one-word instruction buffer that answers repeated fetches without touching memory.
module mesm6_membus_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 48,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ibus_fetch,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic [DATA_W-1:0] ibus_input,
  output logic              ibus_done,
  input  logic              dbus_read,
  input  logic              dbus_write,
  input  logic [ADDR_W-1:0] dbus_addr,
  input  logic [DATA_W-1:0] dbus_output,
  output logic [DATA_W-1:0] dbus_input,
  output logic              dbus_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_t;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_IBUS, GRANT_DBUS} grant_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ibus_input_q, ibus_input_d;
  logic [DATA_W-1:0] dbus_input_q, dbus_input_d;
  logic              dbus_req;
  logic              ibus_wins;
  logic              ibuf_hit;

`ifdef MESM6_IBUF_EN
  logic [ADDR_W-1:0] ibuf_addr_q, ibuf_addr_d;
  logic [DATA_W-1:0] ibuf_data_q, ibuf_data_d;
  logic              ibuf_valid_q, ibuf_valid_d;

  assign ibuf_hit = ibuf_valid_q && (ibus_addr == ibuf_addr_q);
`else
  assign ibuf_hit = 1'b0;
`endif

  assign dbus_req  = dbus_read | dbus_write;
  // ibus only beats a pending dbus request once it has been passed over STARVE_MAX times
  assign ibus_wins = ibus_fetch && (!dbus_req || (starve_cnt_q == STARVE_LIM));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    ibus_input_d = ibus_input_q;
    dbus_input_d = dbus_input_q;
`ifdef MESM6_IBUF_EN
    ibuf_addr_d  = ibuf_addr_q;
    ibuf_data_d  = ibuf_data_q;
    ibuf_valid_d = ibuf_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (ibus_wins) begin
          last_grant_d = GRANT_IBUS;
          starve_cnt_d = '0;
          addr_d       = ibus_addr;
          we_d         = 1'b0;
          if (ibuf_hit) begin
`ifdef MESM6_IBUF_EN
            ibus_input_d = ibuf_data_q;
`endif
            state_d = DONE;
          end else begin
            state_d = IBUS;
          end
        end else if (dbus_req) begin
          last_grant_d = GRANT_DBUS;
          starve_cnt_d = ibus_fetch ? ((starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1)
                                    : 4'd0;
          addr_d       = dbus_addr;
          we_d         = dbus_write;
          wdata_d      = dbus_output;
          state_d      = DBUS;
`ifdef MESM6_IBUF_EN
          if (dbus_write && (dbus_addr == ibuf_addr_q)) ibuf_valid_d = 1'b0;
`endif
        end
      end
      IBUS: begin
        if (mem_ack) begin
          ibus_input_d = mem_rdata;
          state_d      = DONE;
`ifdef MESM6_IBUF_EN
          ibuf_addr_d  = addr_q;
          ibuf_data_d  = mem_rdata;
          ibuf_valid_d = 1'b1;
`endif
        end
      end
      DBUS: begin
        if (mem_ack) begin
          if (!we_q) dbus_input_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_NONE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      ibus_input_q <= '0;
      dbus_input_q <= '0;
`ifdef MESM6_IBUF_EN
      ibuf_addr_q  <= '0;
      ibuf_data_q  <= '0;
      ibuf_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      ibus_input_q <= ibus_input_d;
      dbus_input_q <= dbus_input_d;
`ifdef MESM6_IBUF_EN
      ibuf_addr_q  <= ibuf_addr_d;
      ibuf_data_q  <= ibuf_data_d;
      ibuf_valid_q <= ibuf_valid_d;
`endif
    end
  end

  // mem_req decodes straight from the state flop so an async reset drops it at once
  assign mem_req    = (state_q == IBUS) || (state_q == DBUS);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ibus_input = ibus_input_q;
  assign dbus_input = dbus_input_q;
  assign ibus_done  = (state_q == DONE) && (last_grant_q == GRANT_IBUS);
  assign dbus_done  = (state_q == DONE) && (last_grant_q == GRANT_DBUS);

endmodule

// File: tb/tb_mesm6_membus_arbiter.sv
// Testbench for mesm6_membus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Build with MESM6_IBUF_EN defined to exercise the instruction buffer expectations as well.
module tb_mesm6_membus_arbiter;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 48;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              reset;
  logic              ibus_fetch;
  logic [ADDR_W-1:0] ibus_addr;
  logic [DATA_W-1:0] ibus_input;
  logic              ibus_done;
  logic              dbus_read;
  logic              dbus_write;
  logic [ADDR_W-1:0] dbus_addr;
  logic [DATA_W-1:0] dbus_output;
  logic [DATA_W-1:0] dbus_input;
  logic              dbus_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_wait = 0;
  int wait_cnt = 0;
  logic [DATA_W-1:0] mem_array [64];
  logic [DATA_W-1:0] ref_mem   [64];

  mesm6_membus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr), .dbus_output(dbus_output),
    .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks after mem_wait extra cycles; a write lands when the ack is presented.
  always @(negedge clk) begin
    if (!mem_req) begin
      wait_cnt = 0;
      mem_ack  = 1'b0;
    end else begin
      mem_ack   = (wait_cnt >= mem_wait);
      mem_rdata = mem_array[mem_addr[5:0]];
      if (mem_ack && mem_we) mem_array[mem_addr[5:0]] = mem_wdata;
      wait_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset;
    ibus_fetch = 1'b0; ibus_addr = '0;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_addr = '0; dbus_output = '0;
    mem_wait = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input bit for_ibus, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (for_ibus ? (ibus_done === 1'b1) : (dbus_done === 1'b1)) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    ibus_fetch = 1'b0; ibus_addr = '0;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_addr = '0; dbus_output = '0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, ibus_done, dbus_done} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {mem_req, mem_we, ibus_done, dbus_done});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, ibus_input, dbus_input} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_data: addr %h wdata %h iin %h din %h expected all 0",
                         mem_addr, mem_wdata, ibus_input, dbus_input);
    end
  endtask

  task automatic test_fetch_latency;
    do_reset();
    mem_array[16] = 48'h123456_ABCDEF;
    ibus_fetch = 1'b1; ibus_addr = 15'h0010;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 15'h0010 || mem_we !== 1'b0 || ibus_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fetch_cycle1: req %b addr %h we %b done %b expected 1 0010 0 0",
                         mem_req, mem_addr, mem_we, ibus_done);
    end
    @(negedge clk);
    n_checks++;
    if (ibus_done !== 1'b1 || dbus_done !== 1'b0 || mem_req !== 1'b0 || ibus_input !== 48'h123456_ABCDEF) begin
      n_fail++; $display("[TB] FAIL fetch_cycle2: idone %b ddone %b req %b data %h expected 1 0 0 123456abcdef",
                         ibus_done, dbus_done, mem_req, ibus_input);
    end
    ibus_fetch = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ibus_done !== 1'b0 || ibus_input !== 48'h123456_ABCDEF) begin
      n_fail++; $display("[TB] FAIL fetch_hold: done %b data %h expected 0 123456abcdef", ibus_done, ibus_input);
    end
  endtask

  task automatic test_dbus_write_wait;
    bit got;
    do_reset();
    mem_array[3] = 48'hA5A5_0000_1111;
    dbus_read = 1'b1; dbus_addr = 15'h0003;
    wait_done(1'b0, 10, got);
    n_checks++;
    if (!got || dbus_input !== 48'hA5A5_0000_1111) begin
      n_fail++; $display("[TB] FAIL dread: got_done %b data %h expected 1 a5a500001111", got, dbus_input);
    end
    dbus_read = 1'b0;
    @(negedge clk);
    mem_wait = 3;
    dbus_write = 1'b1; dbus_addr = 15'h7FFF; dbus_output = 48'hFFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'h7FFF ||
          mem_wdata !== 48'hFFFF_FFFF_FFFF || dbus_done !== 1'b0) begin
        n_fail++; $display("[TB] FAIL dwrite_req%0d: req %b we %b addr %h wdata %h done %b expected 1 1 7fff ffffffffffff 0",
                           i, mem_req, mem_we, mem_addr, mem_wdata, dbus_done);
      end
      if (i == 0) begin
        dbus_addr = 15'h0001; dbus_output = 48'h0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (dbus_done !== 1'b1 || mem_req !== 1'b0 || dbus_input !== 48'hA5A5_0000_1111) begin
      n_fail++; $display("[TB] FAIL dwrite_done: done %b req %b din %h expected 1 0 a5a500001111",
                         dbus_done, mem_req, dbus_input);
    end
    dbus_write = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbus_done !== 1'b0 || mem_array[63] !== 48'hFFFF_FFFF_FFFF) begin
      n_fail++; $display("[TB] FAIL dwrite_after: done %b mem %h expected 0 ffffffffffff", dbus_done, mem_array[63]);
    end
  endtask

  task automatic test_starvation;
    int seq [10];
    int n;
    bit both;
    do_reset();
    ibus_fetch = 1'b1; ibus_addr = 15'h0021;
    dbus_read = 1'b1; dbus_addr = 15'h0002;
    n = 0; both = 1'b0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (ibus_done === 1'b1 && dbus_done === 1'b1) both = 1'b1;
      if (ibus_done === 1'b1) begin seq[n] = 1; n++; end
      else if (dbus_done === 1'b1) begin seq[n] = 0; n++; end
    end
    ibus_fetch = 1'b0; dbus_read = 1'b0;
    n_checks++;
    if (n != 10 || both) begin
      n_fail++; $display("[TB] FAIL starve_count: dones %0d overlap %b expected 10 0", n, both);
    end
    for (int p = 0; p < n; p++) begin
      n_checks++;
      if (seq[p] != (((p % (STARVE_MAX + 1)) == STARVE_MAX) ? 1 : 0)) begin
        n_fail++; $display("[TB] FAIL starve_order[%0d]: got %s expected %s", p, seq[p] ? "I" : "D",
                           ((p % (STARVE_MAX + 1)) == STARVE_MAX) ? "I" : "D");
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midtxn;
    bit seen;
    do_reset();
    mem_wait = 20;
    dbus_read = 1'b1; dbus_addr = 15'h0004;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midrst_pre: req %b expected 1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midrst_async: req %b expected 0", mem_req);
    end
    dbus_read = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dbus_done !== 1'b0 || ibus_done !== 1'b0) seen = 1'b1;
    end
    reset = 1'b1; mem_wait = 0;
    repeat (2) begin
      @(negedge clk);
      if (dbus_done !== 1'b0 || ibus_done !== 1'b0 || mem_req !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("[TB] FAIL midrst_quiet: activity seen %b expected 0", seen);
    end
    mem_array[7] = 48'h0000_7777_0007;
    ibus_fetch = 1'b1; ibus_addr = 15'h0007;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ibus_done !== 1'b1 || ibus_input !== 48'h0000_7777_0007) begin
      n_fail++; $display("[TB] FAIL midrst_recover: done %b data %h expected 1 000077770007", ibus_done, ibus_input);
    end
    ibus_fetch = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_write_both;
    int dones, reqs;
    bit we_ok;
    do_reset();
    mem_wait = 1;
    dbus_read = 1'b1; dbus_write = 1'b1; dbus_addr = 15'h0005; dbus_output = 48'h0BAD_CAFE_1234;
    dones = 0; reqs = 0; we_ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        reqs++;
        if (mem_we !== 1'b1) we_ok = 1'b0;
      end
      if (dbus_done === 1'b1) begin
        dones++; dbus_read = 1'b0; dbus_write = 1'b0;
      end
    end
    n_checks++;
    if (dones != 1 || reqs != 2 || !we_ok) begin
      n_fail++; $display("[TB] FAIL rw_both: dones %0d req_cycles %0d we_ok %b expected 1 2 1", dones, reqs, we_ok);
    end
    n_checks++;
    if (mem_array[5] !== 48'h0BAD_CAFE_1234 || dbus_input !== 48'h0) begin
      n_fail++; $display("[TB] FAIL rw_both_data: mem %h din %h expected 0badcafe1234 0", mem_array[5], dbus_input);
    end
  endtask

  task automatic test_ibuf;
    bit got;
    do_reset();
    mem_array[32] = 48'h1111_2222_3333;
    ibus_fetch = 1'b1; ibus_addr = 15'h0020;
    wait_done(1'b1, 10, got);
    ibus_fetch = 1'b0;
    @(negedge clk);
    ibus_fetch = 1'b1;
    @(negedge clk);
`ifdef MESM6_IBUF_EN
    n_checks++;
    if (ibus_done !== 1'b1 || mem_req !== 1'b0 || ibus_input !== 48'h1111_2222_3333) begin
      n_fail++; $display("[TB] FAIL ibuf_hit: done %b req %b data %h expected 1 0 111122223333",
                         ibus_done, mem_req, ibus_input);
    end
    ibus_fetch = 1'b0;
`else
    n_checks++;
    if (ibus_done !== 1'b0 || mem_req !== 1'b1) begin
      n_fail++; $display("[TB] FAIL nobuf_refetch: done %b req %b expected 0 1", ibus_done, mem_req);
    end
    wait_done(1'b1, 10, got);
    ibus_fetch = 1'b0;
`endif
    @(negedge clk);
    dbus_write = 1'b1; dbus_addr = 15'h0020; dbus_output = 48'h4444_5555_6666;
    wait_done(1'b0, 10, got);
    dbus_write = 1'b0;
    @(negedge clk);
    ibus_fetch = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || ibus_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ibuf_inval: req %b done %b expected 1 0", mem_req, ibus_done);
    end
    wait_done(1'b1, 10, got);
    n_checks++;
    if (!got || ibus_input !== 48'h4444_5555_6666) begin
      n_fail++; $display("[TB] FAIL ibuf_refill: got_done %b data %h expected 1 444455556666", got, ibus_input);
    end
    ibus_fetch = 1'b0;
    @(negedge clk);
  endtask

  // Transaction-level model: the arbiter is free one cycle after each done, a memory transaction
  // occupies 1+wait request cycles, and the done pulse follows the acked cycle.
  task automatic test_random;
    int free_cyc, grant_cyc, done_cyc, req_start, req_end, starve, w, ib_gap, db_gap, kind;
    bit done_ibus, ib_active, db_active, dreq;
    logic [ADDR_W-1:0] t_addr;
    logic t_we;
    logic [DATA_W-1:0] t_wdata, done_data, exp_iin, exp_din;
    logic exp_idone, exp_ddone, exp_req;
    bit ib_valid;
    logic [ADDR_W-1:0] ib_addr;
    logic [DATA_W-1:0] ib_data;
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem_array[i];
    free_cyc = 0; grant_cyc = -10; done_cyc = -10; req_start = -10; req_end = -11; starve = 0;
    done_ibus = 1'b0; ib_active = 1'b0; db_active = 1'b0; ib_gap = 1; db_gap = 0;
    t_addr = '0; t_we = 1'b0; t_wdata = '0; done_data = '0;
    exp_iin = '0; exp_din = '0; ib_valid = 1'b0; ib_addr = '0; ib_data = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      exp_idone = (cyc == done_cyc) && done_ibus;
      exp_ddone = (cyc == done_cyc) && !done_ibus;
      exp_req   = (cyc >= req_start) && (cyc <= req_end);
      if (exp_idone) exp_iin = done_data;
      if (exp_ddone && !t_we) exp_din = done_data;
      n_checks++;
      if (ibus_done !== exp_idone || dbus_done !== exp_ddone || mem_req !== exp_req) begin
        n_fail++; $display("[TB] FAIL rnd_ctrl@%0d: idone %b ddone %b req %b expected %b %b %b",
                           cyc, ibus_done, dbus_done, mem_req, exp_idone, exp_ddone, exp_req);
      end
      n_checks++;
      if (ibus_input !== exp_iin || dbus_input !== exp_din) begin
        n_fail++; $display("[TB] FAIL rnd_data@%0d: iin %h din %h expected %h %h", cyc, ibus_input, dbus_input, exp_iin, exp_din);
      end
      if (exp_req) begin
        n_checks++;
        if (mem_addr !== t_addr || mem_we !== t_we || (t_we && mem_wdata !== t_wdata)) begin
          n_fail++; $display("[TB] FAIL rnd_mem@%0d: addr %h we %b wdata %h expected %h %b %h",
                             cyc, mem_addr, mem_we, mem_wdata, t_addr, t_we, t_wdata);
        end
      end
      if (cyc == done_cyc) begin
        if (done_ibus) begin ib_active = 1'b0; ibus_fetch = 1'b0; ib_gap = $urandom_range(0, 3); end
        else begin db_active = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0; db_gap = $urandom_range(0, 3); end
      end
      if (cyc > grant_cyc && cyc < done_cyc && $urandom_range(0, 3) == 0) begin
        if (done_ibus) ibus_addr = ADDR_W'($urandom_range(0, 7));
        else begin dbus_addr = ADDR_W'($urandom_range(0, 7)); dbus_output = DATA_W'({$urandom, $urandom}); end
      end
      if (!ib_active) begin
        if (ib_gap == 0) begin
          ib_active = 1'b1; ibus_fetch = 1'b1; ibus_addr = ADDR_W'($urandom_range(0, 7));
        end else ib_gap--;
      end
      if (!db_active) begin
        if (db_gap == 0) begin
          db_active = 1'b1; kind = $urandom_range(0, 2);
          dbus_read = (kind != 1); dbus_write = (kind != 0);
          dbus_addr = ADDR_W'($urandom_range(0, 7)); dbus_output = DATA_W'({$urandom, $urandom});
        end else db_gap--;
      end
      if (cyc == free_cyc) begin
        dreq = dbus_read | dbus_write;
        if (ibus_fetch && (!dreq || starve == STARVE_MAX)) begin
          starve = 0; done_ibus = 1'b1; t_addr = ibus_addr; t_we = 1'b0; grant_cyc = cyc;
`ifdef MESM6_IBUF_EN
          if (ib_valid && ib_addr == ibus_addr) begin
            done_cyc = cyc + 1; req_start = -10; req_end = -11; done_data = ib_data;
          end else begin
`else
          begin
`endif
            w = $urandom_range(0, 3); mem_wait = w;
            req_start = cyc + 1; req_end = cyc + 1 + w; done_cyc = cyc + 2 + w;
            done_data = ref_mem[t_addr[5:0]];
            ib_valid = 1'b1; ib_addr = t_addr; ib_data = done_data;
          end
          free_cyc = done_cyc + 1;
        end else if (dreq) begin
          starve = ibus_fetch ? ((starve >= STARVE_MAX) ? STARVE_MAX : starve + 1) : 0;
          done_ibus = 1'b0; t_addr = dbus_addr; t_we = dbus_write; t_wdata = dbus_output; grant_cyc = cyc;
          w = $urandom_range(0, 3); mem_wait = w;
          req_start = cyc + 1; req_end = cyc + 1 + w; done_cyc = cyc + 2 + w;
          done_data = ref_mem[t_addr[5:0]];
          if (t_we) begin
            ref_mem[t_addr[5:0]] = t_wdata;
            if (ib_addr == t_addr) ib_valid = 1'b0;
          end
          free_cyc = done_cyc + 1;
        end else begin
          free_cyc = cyc + 1;
        end
      end
      @(negedge clk);
    end
    ibus_fetch = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0;
  endtask

  initial begin
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem_array[i] = DATA_W'({$urandom, $urandom});
    test_reset();
    test_fetch_latency();
    test_dbus_write_wait();
    test_starvation();
    test_reset_midtxn();
    test_read_write_both();
    test_ibuf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
